// File: rtl/fu_join_receiver.sv
// Elastic receiver for a CGRA FU: selects two operands from the four
// neighbour channels, buffers each in a 2-entry FIFO and joins them.
module fu_join_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  assign head = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

module fu_join_receiver #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] north_din,
  input  logic [DATA_WIDTH-1:0] east_din,
  input  logic [DATA_WIDTH-1:0] south_din,
  input  logic [DATA_WIDTH-1:0] west_din,
  input  logic                  north_din_v,
  input  logic                  east_din_v,
  input  logic                  south_din_v,
  input  logic                  west_din_v,
  output logic                  north_din_r,
  output logic                  east_din_r,
  output logic                  south_din_r,
  output logic                  west_din_r,
  input  logic [1:0]            mux_sel_1,
  input  logic [1:0]            mux_sel_2,
  input  logic                  op2_en,
  input  logic                  const_en,
  input  logic [DATA_WIDTH-1:0] const_value,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dout_1,
  output logic [DATA_WIDTH-1:0] dout_2,
  output logic                  dout_v,
  input  logic                  dout_r
);
  logic                  b2_buf;
  logic [3:0]            dv;
  logic [3:0]            used1;
  logic [3:0]            used2;
  logic [3:0]            rdy;
  logic                  full1;
  logic                  full2;
  logic                  push1;
  logic                  push2;
  logic                  pop;
  logic [1:0]            cnt1;
  logic [1:0]            cnt2;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic [DATA_WIDTH-1:0] head1;
  logic [DATA_WIDTH-1:0] head2;

  always_comb begin
    b2_buf = op2_en & ~const_en;
    dv     = {west_din_v, south_din_v, east_din_v, north_din_v};
    used1  = 4'b0001 << mux_sel_1;
    used2  = b2_buf ? (4'b0001 << mux_sel_2) : 4'b0000;
    full1  = (cnt1 == 2'd2);
    full2  = (cnt2 == 2'd2);
    // readies come only from config and registered counts
    rdy    = (used1 | used2)
           & ~(used1 & {4{full1}})
           & ~(used2 & {4{full2}});
    push1  = |(dv & rdy & used1);
    push2  = |(dv & rdy & used2);
    dout_v = (cnt1 != 2'd0) & (~b2_buf | (cnt2 != 2'd0));
    pop    = dout_v & dout_r;
  end

  always_comb begin
    src1 = north_din;
    unique case (mux_sel_1)
      2'd0: src1 = north_din;
      2'd1: src1 = east_din;
      2'd2: src1 = south_din;
      2'd3: src1 = west_din;
    endcase
  end

  always_comb begin
    src2 = north_din;
    unique case (mux_sel_2)
      2'd0: src2 = north_din;
      2'd1: src2 = east_din;
      2'd2: src2 = south_din;
      2'd3: src2 = west_din;
    endcase
  end

  assign north_din_r = rdy[0];
  assign east_din_r  = rdy[1];
  assign south_din_r = rdy[2];
  assign west_din_r  = rdy[3];

  fu_join_fifo #(.W(DATA_WIDTH)) u_b1 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push1),
    .pop   (pop),
    .din   (src1),
    .head  (head1),
    .count (cnt1)
  );

  fu_join_fifo #(.W(DATA_WIDTH)) u_b2 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push2),
    .pop   (pop & b2_buf),
    .din   (src2),
    .head  (head2),
    .count (cnt2)
  );

  always_comb begin
    dout_1 = head1;
    unique case (1'b1)
      b2_buf:   dout_2 = head2;
      const_en: dout_2 = const_value;
      default:  dout_2 = '0;
    endcase
  end
endmodule

// File: tb/tb_fu_join_receiver.sv
// Bench for fu_join_receiver: directed vector table, hand sequences
// and a randomized run against a queue-based reference model.
module tb_fu_join_receiver;
  localparam int DW = 8;

  logic          clk = 0;
  logic          rst;
  logic [DW-1:0] din [4];
  logic [3:0]    vv;
  logic [3:0]    rr;
  logic [1:0]    sel1, sel2;
  logic          op2, cen, clr, dr;
  logic [DW-1:0] cv;
  logic [DW-1:0] d1, d2;
  logic          dv;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fu_join_receiver #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .north_din   (din[0]),
    .east_din    (din[1]),
    .south_din   (din[2]),
    .west_din    (din[3]),
    .north_din_v (vv[0]),
    .east_din_v  (vv[1]),
    .south_din_v (vv[2]),
    .west_din_v  (vv[3]),
    .north_din_r (rr[0]),
    .east_din_r  (rr[1]),
    .south_din_r (rr[2]),
    .west_din_r  (rr[3]),
    .mux_sel_1   (sel1),
    .mux_sel_2   (sel2),
    .op2_en      (op2),
    .const_en    (cen),
    .const_value (cv),
    .clear       (clr),
    .dout_1      (d1),
    .dout_2      (d2),
    .dout_v      (dv),
    .dout_r      (dr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]      s1, s2;
    logic            op2, cen, clr, dr;
    logic [3:0]      v;
    logic [3:0][7:0] d;
    logic            ev;
    logic [7:0]      e1, e2;
    logic [3:0]      er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] s1, input logic [1:0] s2,
    input logic o2, input logic ce, input logic cl, input logic r,
    input logic [3:0] v, input logic [31:0] d,
    input logic ev, input logic [7:0] e1, input logic [7:0] e2,
    input logic [3:0] er);
    vec_t t;
    t.s1 = s1; t.s2 = s2; t.op2 = o2; t.cen = ce; t.clr = cl;
    t.dr = r; t.v = v; t.d = d; t.ev = ev; t.e1 = e1; t.e2 = e2;
    t.er = er;
    return t;
  endfunction

  // reference model state
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];

  task automatic model_step(input string tag);
    logic          buf2;
    logic          u1, u2, ev;
    logic [3:0]    er;
    logic [DW-1:0] e2;
    buf2 = op2 && !cen;
    for (int d = 0; d < 4; d++) begin
      u1 = (int'(sel1) == d);
      u2 = buf2 && (int'(sel2) == d);
      er[d] = (u1 || u2) && (!u1 || q1.size() < 2)
              && (!u2 || q2.size() < 2);
    end
    ev = q1.size() > 0 && (!buf2 || q2.size() > 0);
    chk({tag, " ready"}, int'(rr), int'(er));
    chk({tag, " dout_v"}, int'(dv), int'(ev));
    if (ev) begin
      e2 = buf2 ? q2[0] : (cen ? cv : '0);
      chk({tag, " dout_1"}, int'(d1), int'(q1[0]));
      chk({tag, " dout_2"}, int'(d2), int'(e2));
    end
    if (clr) begin
      q1.delete();
      q2.delete();
    end else begin
      if (ev && dr) begin
        void'(q1.pop_front());
        if (buf2) void'(q2.pop_front());
      end
      if (vv[sel1] && er[sel1]) q1.push_back(din[sel1]);
      if (buf2 && vv[sel2] && er[sel2]) q2.push_back(din[sel2]);
    end
  endtask

  initial begin
    vec_t t;
    rst = 1; clr = 0; dr = 1; vv = 0; cv = 8'h07;
    sel1 = 0; sel2 = 1; op2 = 1; cen = 0;
    for (int i = 0; i < 4; i++) din[i] = '0;

    // latency: north then east, buffered
    tbl.push_back(mk(0,1,1,0,0,1,4'b0000,32'h0,     0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,1,4'b0001,32'h11,    0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,1,4'b0000,32'h0,     0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,1,4'b0010,32'h2200,  0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,1,4'b0000,32'h0,     1,8'h11,8'h22,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,1,4'b0000,32'h0,     0,0,0,4'b0011));
    // backpressure, disabled op2
    tbl.push_back(mk(0,0,0,0,1,0,4'b0000,32'h0,     0,0,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,0,4'b0001,32'h1,     0,0,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,0,4'b0001,32'h2,     1,1,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,0,4'b0001,32'h3,     1,1,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,1,4'b0001,32'h3,     1,1,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,0,1,4'b0001,32'h3,     1,2,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,1,4'b0000,32'h0,     1,3,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,0,1,4'b0000,32'h0,     0,0,0,4'b0001));
    // broadcast west
    tbl.push_back(mk(3,3,1,0,1,1,4'b0000,32'h0,     0,0,0,4'b1000));
    tbl.push_back(mk(3,3,1,0,0,1,4'b1000,32'h0A000000,0,0,0,4'b1000));
    tbl.push_back(mk(3,3,1,0,0,1,4'b1000,32'h0B000000,1,8'h0A,8'h0A,4'b1000));
    tbl.push_back(mk(3,3,1,0,0,1,4'b0000,32'h0,     1,8'h0B,8'h0B,4'b1000));
    tbl.push_back(mk(3,3,1,0,0,1,4'b0000,32'h0,     0,0,0,4'b1000));
    // constant mode
    tbl.push_back(mk(2,1,1,1,1,1,4'b0000,32'h0,     0,0,0,4'b0100));
    tbl.push_back(mk(2,1,1,1,0,1,4'b0110,32'h00036300,0,0,0,4'b0100));
    tbl.push_back(mk(2,1,1,1,0,1,4'b0100,32'h00040000,1,3,7,4'b0100));
    tbl.push_back(mk(2,1,1,1,0,1,4'b0000,32'h0,     1,4,7,4'b0100));
    tbl.push_back(mk(2,1,1,1,0,1,4'b0000,32'h0,     0,0,0,4'b0100));
    // disabled mode, east ignored
    tbl.push_back(mk(2,1,0,0,1,1,4'b0000,32'h0,     0,0,0,4'b0100));
    tbl.push_back(mk(2,1,0,0,0,1,4'b0110,32'h00033700,0,0,0,4'b0100));
    tbl.push_back(mk(2,1,0,0,0,1,4'b0110,32'h00043800,1,3,0,4'b0100));
    tbl.push_back(mk(2,1,0,0,0,1,4'b0000,32'h0,     1,4,0,4'b0100));
    tbl.push_back(mk(2,1,0,0,0,1,4'b0000,32'h0,     0,0,0,4'b0100));
    // flush with both buffers full and a token arriving
    tbl.push_back(mk(0,1,1,0,1,0,4'b0000,32'h0,     0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,0,4'b0011,32'h0201,  0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,0,4'b0011,32'h0403,  1,1,2,4'b0011));
    tbl.push_back(mk(0,1,1,0,1,1,4'b0011,32'h0605,  1,1,2,4'b0000));
    tbl.push_back(mk(0,1,1,0,0,0,4'b0000,32'h0,     0,0,0,4'b0011));
    tbl.push_back(mk(0,1,1,0,0,0,4'b0000,32'h0,     0,0,0,4'b0011));

    #1;
    chk("reset dout_v", int'(dv), 0);
    chk("reset dout_1", int'(d1), 0);
    chk("reset dout_2", int'(d2), 0);
    chk("reset ready", int'(rr), 4'b0011);
    @(negedge clk);
    rst = 0;

    foreach (tbl[i]) begin
      @(negedge clk);
      t = tbl[i];
      sel1 = t.s1; sel2 = t.s2; op2 = t.op2; cen = t.cen;
      clr = t.clr; dr = t.dr; vv = t.v;
      for (int k = 0; k < 4; k++) din[k] = t.d[k];
      #1;
      chk($sformatf("vec%0d ready", i), int'(rr), int'(t.er));
      chk($sformatf("vec%0d dout_v", i), int'(dv), int'(t.ev));
      if (t.ev) begin
        chk($sformatf("vec%0d dout_1", i), int'(d1), int'(t.e1));
        chk($sformatf("vec%0d dout_2", i), int'(d2), int'(t.e2));
      end
    end

    // streaming 0..9 on north and east
    @(negedge clk);
    clr = 0; sel1 = 0; sel2 = 1; op2 = 1; cen = 0; dr = 1;
    for (int k = 0; k < 12; k++) begin
      vv = (k < 10) ? 4'b0011 : 4'b0000;
      din[0] = DW'(k);
      din[1] = DW'(k);
      #1;
      if (k >= 1 && k <= 10) begin
        chk($sformatf("stream%0d dout_v", k), int'(dv), 1);
        chk($sformatf("stream%0d dout_1", k), int'(d1), k - 1);
        chk($sformatf("stream%0d dout_2", k), int'(d2), k - 1);
      end else begin
        chk($sformatf("stream%0d dout_v", k), int'(dv), 0);
      end
      @(negedge clk);
    end

    // async reset with one token held
    sel1 = 0; op2 = 0; cen = 0; dr = 0;
    vv = 4'b0001; din[0] = 8'h5A;
    @(negedge clk);
    vv = 0;
    #1;
    chk("held dout_v", int'(dv), 1);
    chk("held dout_1", int'(d1), 8'h5A);
    #2 rst = 1;
    #1;
    chk("async rst dout_v", int'(dv), 0);
    chk("async rst dout_1", int'(d1), 0);
    chk("async rst ready", int'(rr), 4'b0001);
    cen = 1;
    #1;
    chk("rst const dout_2", int'(d2), 7);
    chk("rst const ready", int'(rr), 4'b0001);
    @(negedge clk);
    rst = 0; cen = 0;

    // randomized run against the queue model
    q1.delete();
    q2.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      clr = (c % 80 == 0) || ($urandom_range(0, 99) == 0);
      if (c % 80 == 0) begin
        sel1 = 2'($urandom);
        sel2 = 2'($urandom);
        op2  = 1'($urandom);
        cen  = ($urandom_range(0, 3) == 0);
        cv   = DW'($urandom);
      end
      vv = 4'($urandom);
      for (int k = 0; k < 4; k++) din[k] = DW'($urandom);
      dr = ($urandom_range(0, 3) != 0);
      #1;
      model_step($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
